// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: parameterised MEM->WB pipeline register for the MIPS core.
//
// Carries DEPTH (1..4) register stages between the memory stage and the
// register file. Each stage holds a valid bit plus the retiring
// instruction's writeback data, write enable, destination, PC, instruction
// word and halt flag.
//
// The writeback data is selected when an entry is captured into stage 0,
// so memtoReg is not carried down the pipe.
//
// The last stage drives the WB outputs. A sticky halt, a forwarding shadow
// of the last retired register write and a saturating retire counter are
// also maintained.
//
// Ports:
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   enable, flush       advance / invalidate all stages (flush wins)
//   *_MEM               entry presented by the memory stage
//   *_WB                last-stage entry; RegWr_WB is the gated write strobe
//   halt_WB             sticky halt, cleared only by reset
//   fwd_valid/wsel/wdat last retired register write (wsel != 0)
//   retired_count       saturating count of retired valid instructions
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              flush,
  input  logic              valid_MEM,
  input  logic [DATA_W-1:0] Output_Port_MEM,
  input  logic [DATA_W-1:0] dmemload_MEM,
  input  logic              memtoReg_MEM,
  input  logic              RegWr_MEM,
  input  logic [REG_AW-1:0] wsel_MEM,
  input  logic [DATA_W-1:0] imemaddr_MEM,
  input  logic [DATA_W-1:0] instr_MEM,
  input  logic              halt_MEM,
  output logic              valid_WB,
  output logic [DATA_W-1:0] wdat_WB,
  output logic              RegWr_WB,
  output logic [REG_AW-1:0] wsel_WB,
  output logic [DATA_W-1:0] imemaddr_WB,
  output logic [DATA_W-1:0] instr_WB,
  output logic              halt_WB,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_wsel,
  output logic [DATA_W-1:0] fwd_wdat,
  output logic [CNT_W-1:0]  retired_count
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH=%0d is illegal, must be 1..4", DEPTH);
  end

  localparam int LAST = DEPTH - 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] wdat;
    logic              regwr;
    logic [REG_AW-1:0] wsel;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              halt;
  } stage_t;

  stage_t             stage_q [DEPTH];
  stage_t             stage_d [DEPTH];
  stage_t             mem_entry;
  stage_t             last_in;
  logic               load_last;
  logic               retire;
  logic               halt_q, halt_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [REG_AW-1:0]  fwd_wsel_q, fwd_wsel_d;
  logic [DATA_W-1:0]  fwd_wdat_q, fwd_wdat_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Writeback data is resolved at capture time.
  always_comb begin : capture
    mem_entry.valid = valid_MEM;
    mem_entry.wdat  = memtoReg_MEM ? dmemload_MEM : Output_Port_MEM;
    mem_entry.regwr = RegWr_MEM;
    mem_entry.wsel  = wsel_MEM;
    mem_entry.pc    = imemaddr_MEM;
    mem_entry.instr = instr_MEM;
    mem_entry.halt  = halt_MEM;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps the logic free of inferred latches.
  always_comb begin : stage_next
    stage_d = stage_q;
    if (flush) begin
      // Only valid bits are cleared; stale data is harmless once invalid.
      for (int k = 0; k < DEPTH; k++) stage_d[k].valid = 1'b0;
    end else if (enable) begin
      stage_d[0] = mem_entry;
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end
  end

  // When the last stage loads, stage_d[LAST] is exactly the incoming entry,
  // which avoids a separate DEPTH==1 special case.
  assign load_last = enable & ~flush;
  assign last_in   = stage_d[LAST];
  assign retire    = load_last & last_in.valid & ~halt_q;

  always_comb begin : side_next
    halt_d      = halt_q | (load_last & last_in.valid & last_in.halt);
    count_d     = count_q;
    fwd_valid_d = fwd_valid_q;
    fwd_wsel_d  = fwd_wsel_q;
    fwd_wdat_d  = fwd_wdat_q;
    if (retire) begin
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
      if (last_in.regwr && last_in.wsel != '0) begin
        fwd_valid_d = 1'b1;
        fwd_wsel_d  = last_in.wsel;
        fwd_wdat_d  = last_in.wdat;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  // NOTE: the stage array is reset in full (data as well as valid bits)
  // because all outputs must read zero while RST is held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      halt_q      <= 1'b0;
      count_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_wsel_q  <= '0;
      fwd_wdat_q  <= '0;
    end else begin
      stage_q     <= stage_d;
      halt_q      <= halt_d;
      count_q     <= count_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_wsel_q  <= fwd_wsel_d;
      fwd_wdat_q  <= fwd_wdat_d;
    end
  end

  assign valid_WB      = stage_q[LAST].valid;
  assign wdat_WB       = stage_q[LAST].wdat;
  assign RegWr_WB      = stage_q[LAST].valid & stage_q[LAST].regwr & ~halt_q;
  assign wsel_WB       = stage_q[LAST].wsel;
  assign imemaddr_WB   = stage_q[LAST].pc;
  assign instr_WB      = stage_q[LAST].instr;
  assign halt_WB       = halt_q;
  assign fwd_valid     = fwd_valid_q;
  assign fwd_wsel      = fwd_wsel_q;
  assign fwd_wdat      = fwd_wdat_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe. Four instances share one stimulus stream:
// DEPTH=1..4, with the DEPTH=2 instance using a 4-bit retire counter.
// A queue-based reference model predicts every output.
module tb_mem_wb_pipe;

  logic        CLK;
  logic        RST;
  logic        enable;
  logic        flush;
  logic        valid_MEM;
  logic [31:0] Output_Port_MEM;
  logic [31:0] dmemload_MEM;
  logic        memtoReg_MEM;
  logic        RegWr_MEM;
  logic [4:0]  wsel_MEM;
  logic [31:0] imemaddr_MEM;
  logic [31:0] instr_MEM;
  logic        halt_MEM;

  logic        valid_o [4];
  logic [31:0] wdat_o  [4];
  logic        regwr_o [4];
  logic [4:0]  wsel_o  [4];
  logic [31:0] pc_o    [4];
  logic [31:0] instr_o [4];
  logic        halt_o  [4];
  logic        fv_o    [4];
  logic [4:0]  fs_o    [4];
  logic [31:0] fd_o    [4];
  logic [31:0] cnt_o   [4];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 1) ? 4 : 32;
    logic [CW-1:0] cnt;
    mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .DEPTH(g + 1), .CNT_W(CW)) u_dut (
      .CLK             (CLK),
      .RST             (RST),
      .enable          (enable),
      .flush           (flush),
      .valid_MEM       (valid_MEM),
      .Output_Port_MEM (Output_Port_MEM),
      .dmemload_MEM    (dmemload_MEM),
      .memtoReg_MEM    (memtoReg_MEM),
      .RegWr_MEM       (RegWr_MEM),
      .wsel_MEM        (wsel_MEM),
      .imemaddr_MEM    (imemaddr_MEM),
      .instr_MEM       (instr_MEM),
      .halt_MEM        (halt_MEM),
      .valid_WB        (valid_o[g]),
      .wdat_WB         (wdat_o[g]),
      .RegWr_WB        (regwr_o[g]),
      .wsel_WB         (wsel_o[g]),
      .imemaddr_WB     (pc_o[g]),
      .instr_WB        (instr_o[g]),
      .halt_WB         (halt_o[g]),
      .fwd_valid       (fv_o[g]),
      .fwd_wsel        (fs_o[g]),
      .fwd_wdat        (fd_o[g]),
      .retired_count   (cnt)
    );
    assign cnt_o[g] = 32'(cnt);
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit        valid;
    bit [31:0] wdat;
    bit        regwr;
    bit [4:0]  wsel;
    bit [31:0] pc;
    bit [31:0] instr;
    bit        halt;
  } ent_t;

  ent_t        pipe_m [4][$];   // index 0 = newest stage, index d = WB
  bit          halt_m [4];
  longint      cnt_m  [4];
  bit          fv_m   [4];
  bit [4:0]    fs_m   [4];
  bit [31:0]   fd_m   [4];
  longint      cmax_m [4] = '{32'hFFFF_FFFF, 15, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  task automatic model_reset();
    ent_t z;
    z = '{default: 0};
    for (int d = 0; d < 4; d++) begin
      pipe_m[d].delete();
      for (int i = 0; i <= d; i++) pipe_m[d].push_back(z);
      halt_m[d] = 0;
      cnt_m[d]  = 0;
      fv_m[d]   = 0;
      fs_m[d]   = 0;
      fd_m[d]   = 0;
    end
  endtask

  // Applies the current inputs as one clock edge to every model instance.
  task automatic model_edge();
    ent_t e, last, t;
    e.valid = valid_MEM;
    e.wdat  = memtoReg_MEM ? dmemload_MEM : Output_Port_MEM;
    e.regwr = RegWr_MEM;
    e.wsel  = wsel_MEM;
    e.pc    = imemaddr_MEM;
    e.instr = instr_MEM;
    e.halt  = halt_MEM;
    for (int d = 0; d < 4; d++) begin
      if (flush) begin
        for (int i = 0; i < pipe_m[d].size(); i++) begin
          t = pipe_m[d][i];
          t.valid = 0;
          pipe_m[d][i] = t;
        end
      end else if (enable) begin
        pipe_m[d].push_front(e);
        void'(pipe_m[d].pop_back());
        last = pipe_m[d][d];
        if (last.valid && !halt_m[d]) begin
          if (cnt_m[d] < cmax_m[d]) cnt_m[d]++;
          if (last.regwr && last.wsel != 0) begin
            fv_m[d] = 1;
            fs_m[d] = last.wsel;
            fd_m[d] = last.wdat;
          end
        end
        if (last.valid && last.halt) halt_m[d] = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t w;
    for (int d = 0; d < 4; d++) begin
      w = pipe_m[d][d];
      chk($sformatf("d%0d valid_WB", d + 1), 32'(valid_o[d]), 32'(w.valid));
      chk($sformatf("d%0d halt_WB", d + 1), 32'(halt_o[d]), 32'(halt_m[d]));
      chk($sformatf("d%0d RegWr_WB", d + 1), 32'(regwr_o[d]),
          32'(w.valid && w.regwr && !halt_m[d]));
      if (w.valid) begin
        chk($sformatf("d%0d wdat_WB", d + 1), wdat_o[d], w.wdat);
        chk($sformatf("d%0d wsel_WB", d + 1), 32'(wsel_o[d]), 32'(w.wsel));
        chk($sformatf("d%0d imemaddr_WB", d + 1), pc_o[d], w.pc);
        chk($sformatf("d%0d instr_WB", d + 1), instr_o[d], w.instr);
      end
      chk($sformatf("d%0d fwd_valid", d + 1), 32'(fv_o[d]), 32'(fv_m[d]));
      chk($sformatf("d%0d fwd_wsel", d + 1), 32'(fs_o[d]), 32'(fs_m[d]));
      chk($sformatf("d%0d fwd_wdat", d + 1), fd_o[d], fd_m[d]);
      chk($sformatf("d%0d retired_count", d + 1), cnt_o[d], 32'(cnt_m[d]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int pc_ctr = 32'h400;

  task automatic set_mem(input bit v, input bit [31:0] alu, input bit [31:0] ld,
                         input bit m2r, input bit rw, input bit [4:0] ws, input bit h);
    enable          = 1'b1;
    flush           = 1'b0;
    valid_MEM       = v;
    Output_Port_MEM = alu;
    dmemload_MEM    = ld;
    memtoReg_MEM    = m2r;
    RegWr_MEM       = rw;
    wsel_MEM        = ws;
    imemaddr_MEM    = pc_ctr;
    instr_MEM       = $urandom;
    halt_MEM        = h;
    pc_ctr += 4;
  endtask

  task automatic set_idle();
    set_mem(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic set_rand();
    set_mem($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
            1'($urandom), 5'($urandom), 1'b0);
    enable = $urandom_range(0, 4) != 0;
    flush  = $urandom_range(0, 9) == 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_idle();
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    longint n_halt;
    RST = 1'b0;
    set_idle();
    #2;
    do_reset();

    // ALU op retires after one cycle at DEPTH=1.
    set_mem(1'b1, 32'h0000_00AA, 32'h1234_5678, 1'b0, 1'b1, 5'd3, 1'b0);
    step();
    chk("alu d1 wdat", wdat_o[0], 32'hAA);
    chk("alu d1 regwr", 32'(regwr_o[0]), 32'd1);
    chk("alu d1 fwd_wsel", 32'(fs_o[0]), 32'd3);
    chk("alu d1 fwd_wdat", fd_o[0], 32'hAA);
    chk("alu d1 count", cnt_o[0], 32'd1);

    // Load reaches WB of DEPTH=3 after exactly three edges.
    do_reset();
    set_mem(1'b1, 32'h5555_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd9, 1'b0);
    step();
    chk("load d3 bubble1", 32'(valid_o[2]), 32'd0);
    set_idle();
    step();
    chk("load d3 bubble2", 32'(valid_o[2]), 32'd0);
    step();
    chk("load d3 valid", 32'(valid_o[2]), 32'd1);
    chk("load d3 wdat", wdat_o[2], 32'hDEAD_BEEF);

    // Stall with a valid entry sitting in the DEPTH=2 last stage.
    do_reset();
    set_mem(1'b1, 32'h0000_0077, 32'h0, 1'b0, 1'b1, 5'd7, 1'b0);
    step();
    set_idle();
    step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall d2 regwr", 32'(regwr_o[1]), 32'd1);
      chk("stall d2 count", cnt_o[1], 32'd1);
    end

    // Flush together with enable=0, two valid entries in flight.
    do_reset();
    set_mem(1'b1, 32'h0000_0011, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0);
    step();
    set_mem(1'b1, 32'h0000_0022, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0);
    step();
    enable = 1'b0;
    flush  = 1'b1;
    step();
    chk("flush d2 valid", 32'(valid_o[1]), 32'd0);
    chk("flush d2 regwr", 32'(regwr_o[1]), 32'd0);
    chk("flush d2 count", cnt_o[1], 32'd1);
    chk("flush d2 fwd_wsel", 32'(fs_o[1]), 32'd4);

    // $0 write does not update forwarding; then drive the 4-bit counter
    // past saturation.
    do_reset();
    set_mem(1'b1, 32'h0000_0055, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
    step();
    set_mem(1'b1, 32'h0000_0066, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
    step();
    chk("wsel0 d1 fwd_wsel", 32'(fs_o[0]), 32'd5);
    chk("wsel0 d1 fwd_wdat", fd_o[0], 32'h55);
    for (int i = 0; i < 17; i++) begin
      set_mem(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 1'b0);
      step();
    end
    chk("sat d2 count", cnt_o[1], 32'd15);
    for (int i = 0; i < 60; i++) begin
      set_rand();
      step();
    end
    chk("sat d2 count after random", cnt_o[1], 32'd15);

    // Halt: counted itself, then freezes counting, forwarding and writes.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_mem(1'b1, $urandom, $urandom, 1'b0, 1'b1, 5'(i + 1), 1'b0);
      step();
    end
    n_halt = cnt_m[0];
    set_mem(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    step();
    chk("halt d1 halt_WB", 32'(halt_o[0]), 32'd1);
    chk("halt d1 count", cnt_o[0], 32'(n_halt + 1));
    for (int i = 0; i < 6; i++) begin
      set_mem(1'b1, $urandom, $urandom, 1'b0, 1'b1, 5'd12, 1'b0);
      step();
      chk("halt d1 regwr", 32'(regwr_o[0]), 32'd0);
      chk("halt d1 count frozen", cnt_o[0], 32'(n_halt + 1));
    end
    enable = 1'b0;
    flush  = 1'b1;
    step();
    chk("halt d4 after flush", 32'(halt_o[3]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_rand();
      step();
    end

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async d4 halt", 32'(halt_o[3]), 32'd0);
    chk("async d1 count", cnt_o[0], 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    set_idle();
    step();
    for (int i = 0; i < 20; i++) begin
      set_rand();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline register for the MIPS core; successor to the fixed single-stage MEM/WB latch.
- Configurable depth of 1..4 register stages, and a per-entry valid bit for bubble tracking.
- Selects the writeback data (ALU result vs. memory load) at capture, gates the regfile write strobe, and tracks a sticky halt.
- Keeps a forwarding shadow of the last retired register write, plus a saturating retire counter. Sits between the memory stage and the register file / hazard unit.

Parameters:
DATA_W, 32, width of data words and result paths
REG_AW, 5, register index width
DEPTH, 1, number of MEM→WB register stages (legal 1..4)
CNT_W, 32, retire counter width

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-high reset
enable  in  1  advance all stages when 1; hold when 0 (stall)
flush  in  1  invalidate all in-flight entries
valid_MEM  in  1  MEM entry holds a real instruction
Output_Port_MEM  in  DATA_W  ALU result
dmemload_MEM  in  DATA_W  data memory load value
memtoReg_MEM  in  1  1: write back load value, 0: ALU result
RegWr_MEM  in  1  instruction writes a register
wsel_MEM  in  REG_AW  destination register index
imemaddr_MEM  in  DATA_W  instruction PC
instr_MEM  in  DATA_W  instruction word
halt_MEM  in  1  halt instruction
valid_WB  out  1  WB entry valid
wdat_WB  out  DATA_W  selected writeback data
RegWr_WB  out  1  regfile write strobe, gated
wsel_WB  out  REG_AW  destination index
imemaddr_WB  out  DATA_W  PC of WB entry
instr_WB  out  DATA_W  instruction of WB entry
halt_WB  out  1  sticky halt
fwd_valid  out  1  shadow holds a retired write
fwd_wsel  out  REG_AW  shadow destination
fwd_wdat  out  DATA_W  shadow data
retired_count  out  CNT_W  retired valid instructions

Behaviour:
- Reset (async, RST=1): all stage fields, valid bits, halt_WB, fwd_* and retired_count go to 0 immediately. All outputs are 0 while RST is held.
- Capture mux: stage 0 stores wdat = memtoReg_MEM ? dmemload_MEM : Output_Port_MEM. memtoReg is not carried downstream.
- Shift: on a rising edge with enable=1 and flush=0:
  - stage 0 ← MEM inputs;
  - stage k ← stage k-1.
  - The WB outputs are the last stage (index DEPTH-1).
  - Latency from MEM inputs to WB outputs is DEPTH cycles.
- Stall: enable=0 and flush=0 → every stage holds, including valid bits.
- Flush: flush=1 clears every stage's valid bit (data fields are don't-care) on that edge, regardless of enable. flush takes priority over enable. The MEM entry presented on that cycle is dropped.
- RegWr_WB = valid_WB & RegWr(last stage) & ~halt_WB. It is combinational from registered state.
- halt_WB:
  - Set on the edge where the last stage is loaded with valid=1 and halt=1.
  - Stays 1 until reset; flush does not clear it.
  - Once set, no further retirements count, no forwarding updates occur, and RegWr_WB is forced to 0.
- Retire event: an edge where the last stage is loaded (enable=1, flush=0) with a valid entry, and halt_WB is 0 before that edge. A stalled entry counts once only.
  - The halt instruction itself counts as retired.
- retired_count increments by 1 per retire event and saturates at all-ones.
- Forwarding shadow:
  - On a retire event whose entry has RegWr=1 and wsel≠0: fwd_valid←1, fwd_wsel←wsel, fwd_wdat←wdat.
  - Otherwise fwd_* hold.
  - Not cleared by flush, because retired state is architectural.
- Simultaneous flush and stall: flush wins; valid bits clear.
- Illegal DEPTH (outside 1..4) is a configuration error, and the RTL must flag it at elaboration.

Test Plan:
- DEPTH=1, reset then valid ALU op, Output_Port_MEM=0x0000_00AA, wsel=3, RegWr=1, memtoReg=0 → next cycle valid_WB=1, wdat_WB=0xAA, RegWr_WB=1; fwd_wsel=3, fwd_wdat=0xAA; retired_count=1.
- DEPTH=3, load with memtoReg=1, dmemload_MEM=0xDEAD_BEEF → wdat_WB=0xDEADBEEF exactly 3 cycles later; valid_WB=0 in the two cycles before.
- DEPTH=2, enable=0 for 4 cycles with a valid entry in the last stage → outputs held and RegWr_WB stays 1; retired_count increments by 1 only.
- DEPTH=2, two valid entries in flight, pulse flush together with enable=0 → both valid bits 0; RegWr_WB=0; fwd_* and retired_count unchanged.
- Halt retires at count N → halt_WB=1 and count=N+1. Later valid writes: RegWr_WB=0, count frozen, fwd unchanged. A flush leaves halt_WB=1, and RST clears everything asynchronously mid-cycle.
- Write to wsel=0, then CNT_W=4 with 17 retirements → fwd unchanged by the $0 write; retired_count saturates at 15.
